// File: rtl/button_event_classifier_if.sv
// rtl/button_event_classifier_if.sv - debounced button inputs and classified gesture events
interface button_event_classifier_if;
  logic pb_state;
  logic pb_down;
  logic pb_up;
  logic short_press;
  logic long_press;
  logic repeat_tick;
  logic double_click;
  logic busy;

  modport master (
    output pb_state, pb_down, pb_up,
    input  short_press, long_press, repeat_tick, double_click, busy
  );

  modport slave (
    input  pb_state, pb_down, pb_up,
    output short_press, long_press, repeat_tick, double_click, busy
  );
endinterface

// File: rtl/button_event_classifier.sv
// rtl/button_event_classifier.sv - classifies debounced button activity into short/long/repeat/double-click pulses
module button_event_classifier #(
  parameter int CNT_W         = 24,
  parameter int LONG_CYCLES   = 12_500_000,
  parameter int DCLICK_CYCLES = 10_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter bit REPEAT_EN     = 1'b1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  button_event_classifier_if.slave    bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESSED,
    S_LONG_HELD,
    S_WAIT2,
    S_PRESS2
  } state_t;

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_CYCLES - 1);
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_lost, w_lost_nxt;
  logic             r_short, w_short_nxt;
  logic             r_long, w_long_nxt;
  logic             r_repeat, w_repeat_nxt;
  logic             r_dclick, w_dclick_nxt;
  logic             r_busy;

  logic w_down, w_up, w_released, w_lost_exit;
  logic w_cnt_long, w_cnt_dclick, w_cnt_repeat;

  // Simultaneous down and up pulses cancel each other out.
  assign w_down       = bus.pb_down & ~bus.pb_up;
  assign w_up         = bus.pb_up & ~bus.pb_down;
  assign w_released   = ~bus.pb_state & ~w_up;
  assign w_lost_exit  = r_lost & w_released;
  assign w_cnt_long   = (r_cnt == LONG_LAST);
  assign w_cnt_dclick = (r_cnt == DCLICK_LAST);
  assign w_cnt_repeat = (r_cnt == REPEAT_LAST);

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt + CNT_ONE;
    w_lost_nxt   = 1'b0;
    w_short_nxt  = 1'b0;
    w_long_nxt   = 1'b0;
    w_repeat_nxt = 1'b0;
    w_dclick_nxt = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (w_down) w_state_nxt = S_PRESSED;
      end
      S_PRESSED: begin
        if (w_up) begin
          w_state_nxt = S_WAIT2;
        end else if (w_lost_exit) begin
          w_state_nxt = S_IDLE;
        end else if (w_cnt_long) begin
          w_state_nxt = S_LONG_HELD;
          w_long_nxt  = 1'b1;
        end else begin
          w_lost_nxt  = w_released;
        end
      end
      S_LONG_HELD: begin
        if (w_up || w_lost_exit) begin
          w_state_nxt = S_IDLE;
        end else begin
          w_lost_nxt = w_released;
          if (REPEAT_EN && w_cnt_repeat) begin
            w_repeat_nxt = 1'b1;
            w_cnt_nxt    = '0;
          end
        end
      end
      S_WAIT2: begin
        // A press landing on the timeout cycle still counts as the second click.
        if (w_down) begin
          w_state_nxt = S_PRESS2;
        end else if (w_cnt_dclick) begin
          w_state_nxt = S_IDLE;
          w_short_nxt = 1'b1;
        end
      end
      S_PRESS2: begin
        if (w_up) begin
          w_state_nxt  = S_IDLE;
          w_dclick_nxt = 1'b1;
        end else if (w_lost_exit) begin
          w_state_nxt = S_IDLE;
        end else if (w_cnt_long) begin
          w_state_nxt = S_LONG_HELD;
          w_long_nxt  = 1'b1;
        end else begin
          w_lost_nxt  = w_released;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_state_nxt != r_state || r_state == S_IDLE) w_cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_lost   <= 1'b0;
      r_short  <= 1'b0;
      r_long   <= 1'b0;
      r_repeat <= 1'b0;
      r_dclick <= 1'b0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_lost   <= w_lost_nxt;
      r_short  <= w_short_nxt;
      r_long   <= w_long_nxt;
      r_repeat <= w_repeat_nxt;
      r_dclick <= w_dclick_nxt;
      r_busy   <= (w_state_nxt != S_IDLE);
    end
  end

  assign bus.short_press  = r_short;
  assign bus.long_press   = r_long;
  assign bus.repeat_tick  = r_repeat;
  assign bus.double_click = r_dclick;
  assign bus.busy         = r_busy;

endmodule

// File: tb/tb_button_event_classifier.sv
// tb/tb_button_event_classifier.sv - directed and randomized gesture checks for button_event_classifier
module tb_button_event_classifier;
  localparam int LONG   = 8;
  localparam int DCLICK = 5;
  localparam int REPEAT = 4;
  localparam int MAXC   = 400;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;

  button_event_classifier_if bus ();

  button_event_classifier #(
    .CNT_W(8), .LONG_CYCLES(LONG), .DCLICK_CYCLES(DCLICK),
    .REPEAT_CYCLES(REPEAT), .REPEAT_EN(1'b1)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  // Event vector bit order: {busy, double_click, repeat_tick, long_press, short_press}
  logic       s_down [MAXC];
  logic       s_up [MAXC];
  logic       s_state [MAXC];
  logic       s_rst [MAXC];
  logic [4:0] exp_ev [MAXC];
  logic [4:0] obs_ev [MAXC];
  int         q_d[$];
  int         q_u[$];

  task automatic clear_all();
    for (int c = 0; c < MAXC; c++) begin
      s_down[c] = 1'b0; s_up[c] = 1'b0; s_state[c] = 1'b0; s_rst[c] = 1'b0;
      exp_ev[c] = '0; obs_ev[c] = '0;
    end
    q_d.delete();
    q_u.delete();
  endtask

  task automatic press(input int d, input int u);
    s_down[d] = 1'b1;
    s_up[u] = 1'b1;
    for (int c = d; c < u; c++) s_state[c] = 1'b1;
    q_d.push_back(d);
    q_u.push_back(u);
  endtask

  task automatic mark(input int b, input int lo, input int hi);
    for (int c = lo; c <= hi; c++) exp_ev[c][b] = 1'b1;
  endtask

  task automatic run(input int n);
    bus.pb_state = 1'b0; bus.pb_down = 1'b0; bus.pb_up = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int t = 0; t < n; t++) begin
      rst_n        = ~s_rst[t];
      bus.pb_state = s_state[t];
      bus.pb_down  = s_down[t];
      bus.pb_up    = s_up[t];
      @(negedge clk);
      obs_ev[t] = {bus.busy, bus.double_click, bus.repeat_tick, bus.long_press, bus.short_press};
      @(posedge clk);
      #1;
    end
    bus.pb_state = 1'b0; bus.pb_down = 1'b0; bus.pb_up = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic model_long(input int d, input int u);
    mark(1, d + LONG + 1, d + LONG + 1);
    for (int t = d + LONG + 1 + REPEAT; t <= u; t += REPEAT) mark(2, t, t);
  endtask

  // Gesture-level reference: decides each gesture's meaning from press/release timestamps.
  task automatic model();
    int i = 0;
    while (i < q_d.size()) begin
      int d = q_d[i];
      int u = q_u[i];
      if (u > d + LONG) begin
        model_long(d, u);
        mark(4, d + 1, u);
        i += 1;
      end else if (i + 1 < q_d.size() && q_d[i + 1] <= u + DCLICK) begin
        int d2 = q_d[i + 1];
        int u2 = q_u[i + 1];
        if (u2 <= d2 + LONG) mark(3, u2 + 1, u2 + 1);
        else model_long(d2, u2);
        mark(4, d + 1, u2);
        i += 2;
      end else begin
        mark(0, u + DCLICK + 1, u + DCLICK + 1);
        mark(4, d + 1, u + DCLICK);
        i += 1;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.pb_state = 1'b1; bus.pb_down = 1'b1; bus.pb_up = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (bus.short_press !== 1'b0) begin fails++; $display("FAIL reset_short got %b expected 0", bus.short_press); end
    tests++; if (bus.long_press !== 1'b0) begin fails++; $display("FAIL reset_long got %b expected 0", bus.long_press); end
    tests++; if (bus.repeat_tick !== 1'b0) begin fails++; $display("FAIL reset_repeat got %b expected 0", bus.repeat_tick); end
    tests++; if (bus.double_click !== 1'b0) begin fails++; $display("FAIL reset_dclick got %b expected 0", bus.double_click); end
    tests++; if (bus.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b expected 0", bus.busy); end
  endtask

  task automatic test_short_press();
    clear_all();
    press(0, 3);
    mark(0, 9, 9); mark(4, 1, 8);
    run(20);
    for (int t = 0; t < 20; t++) begin
      tests++;
      if (obs_ev[t] !== exp_ev[t]) begin fails++; $display("FAIL short_press cycle %0d busy/dbl/rpt/long/short got %b expected %b", t, obs_ev[t], exp_ev[t]); end
    end
  endtask

  task automatic test_long_repeat();
    clear_all();
    press(0, 20);
    mark(1, 9, 9); mark(2, 13, 13); mark(2, 17, 17); mark(4, 1, 20);
    run(30);
    for (int t = 0; t < 30; t++) begin
      tests++;
      if (obs_ev[t] !== exp_ev[t]) begin fails++; $display("FAIL long_repeat cycle %0d busy/dbl/rpt/long/short got %b expected %b", t, obs_ev[t], exp_ev[t]); end
    end
  endtask

  task automatic test_double_click();
    clear_all();
    press(0, 2); press(5, 7);
    mark(3, 8, 8); mark(4, 1, 7);
    run(20);
    for (int t = 0; t < 20; t++) begin
      tests++;
      if (obs_ev[t] !== exp_ev[t]) begin fails++; $display("FAIL double_click cycle %0d busy/dbl/rpt/long/short got %b expected %b", t, obs_ev[t], exp_ev[t]); end
    end
  endtask

  task automatic test_late_second();
    clear_all();
    press(0, 2); press(8, 10);
    mark(0, 8, 8); mark(4, 1, 7); mark(0, 16, 16); mark(4, 9, 15);
    run(25);
    for (int t = 0; t < 25; t++) begin
      tests++;
      if (obs_ev[t] !== exp_ev[t]) begin fails++; $display("FAIL late_second cycle %0d busy/dbl/rpt/long/short got %b expected %b", t, obs_ev[t], exp_ev[t]); end
    end
  endtask

  task automatic test_race();
    clear_all();
    press(0, 2); press(7, 9);
    mark(3, 10, 10); mark(4, 1, 9);
    run(20);
    for (int t = 0; t < 20; t++) begin
      tests++;
      if (obs_ev[t] !== exp_ev[t]) begin fails++; $display("FAIL wait2_race cycle %0d busy/dbl/rpt/long/short got %b expected %b", t, obs_ev[t], exp_ev[t]); end
    end
  endtask

  task automatic test_lost_pulse();
    clear_all();
    s_down[0] = 1'b1;
    for (int c = 0; c < 3; c++) s_state[c] = 1'b1;
    mark(4, 1, 4);
    run(20);
    for (int t = 0; t < 20; t++) begin
      tests++;
      if (obs_ev[t] !== exp_ev[t]) begin fails++; $display("FAIL lost_pulse cycle %0d busy/dbl/rpt/long/short got %b expected %b", t, obs_ev[t], exp_ev[t]); end
    end
  endtask

  task automatic test_reset_mid_press();
    clear_all();
    s_down[0] = 1'b1;
    for (int c = 0; c < 16; c++) s_state[c] = 1'b1;
    s_rst[4] = 1'b1;
    s_down[18] = 1'b1; s_up[18] = 1'b1;
    mark(4, 1, 3);
    run(25);
    for (int t = 0; t < 25; t++) begin
      tests++;
      if (obs_ev[t] !== exp_ev[t]) begin fails++; $display("FAIL reset_mid_press cycle %0d busy/dbl/rpt/long/short got %b expected %b", t, obs_ev[t], exp_ev[t]); end
    end
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      int t = 2;
      int n;
      clear_all();
      while (t < 300) begin
        int hold = int'($urandom_range(1, 16));
        int gap  = int'($urandom_range(1, 10));
        press(t, t + hold);
        t = t + hold + gap;
      end
      model();
      n = t + 20;
      run(n);
      for (int c = 0; c < n; c++) begin
        tests++;
        if (obs_ev[c] !== exp_ev[c]) begin fails++; $display("FAIL random%0d cycle %0d busy/dbl/rpt/long/short got %b expected %b", r, c, obs_ev[c], exp_ev[c]); end
      end
    end
  endtask

  initial begin
    bus.pb_state = 1'b0; bus.pb_down = 1'b0; bus.pb_up = 1'b0;
    test_reset();
    test_short_press();
    test_long_repeat();
    test_double_click();
    test_late_second();
    test_race();
    test_lost_pulse();
    test_reset_mid_press();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
